// File: rtl/ext_mem_be_arb.sv
// ext_mem_be_arb: round-robin arbiter from icache/dcache back-end buses onto one L2 front-end.
// Latency: request in IDLE -> s_req_o next cycle; s_ack_i -> master ack next cycle; one access outstanding.
// Backpressure: masters hold req until ack; the L2 stalls by withholding s_ack_i. Optional grant
// counters are built when EXT_MEM_BE_ARB_STATS_EN is defined, otherwise the counter ports read 0.
module ext_mem_be_arb #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  i_req_i,
  input  logic [ADDR_W-1:0]     i_addr_i,
  input  logic [DATA_W-1:0]     i_wdata_i,
  input  logic [DATA_W/8-1:0]   i_wstrb_i,
  output logic [DATA_W-1:0]     i_rdata_o,
  output logic                  i_ack_o,
  input  logic                  d_req_i,
  input  logic [ADDR_W-1:0]     d_addr_i,
  input  logic [DATA_W-1:0]     d_wdata_i,
  input  logic [DATA_W/8-1:0]   d_wstrb_i,
  output logic [DATA_W-1:0]     d_rdata_o,
  output logic                  d_ack_o,
  input  logic                  inval_req_i,
  output logic                  s_req_o,
  output logic [ADDR_W-1:0]     s_addr_o,
  output logic [DATA_W-1:0]     s_wdata_o,
  output logic [DATA_W/8-1:0]   s_wstrb_o,
  input  logic [DATA_W-1:0]     s_rdata_i,
  input  logic                  s_ack_i,
  output logic                  inval_o,
  output logic [31:0]           i_grant_cnt_o,
  output logic [31:0]           d_grant_cnt_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, INVAL} state_t;

  state_t              state_q;
  logic                gnt_d_q;      // master owning the outstanding access (1 = dcache)
  logic                last_d_q;     // master granted most recently (1 = dcache)
  logic                inval_pend_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                pick_d;
  logic                grant;

  // On a tie the master not granted last wins; a lone requester always wins.
  assign pick_d = d_req_i & (~i_req_i | ~last_d_q);
  // A grant happens only from IDLE when no invalidate is waiting.
  assign grant  = (state_q == IDLE) & ~inval_pend_q & (i_req_i | d_req_i);

  // Main sequencer: one access or one invalidate at a time, all outputs registered.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= IDLE;
      gnt_d_q  <= 1'b0;
      last_d_q <= 1'b1;
      s_req_o  <= 1'b0;
      s_addr_o <= '0;
      s_wdata_o <= '0;
      s_wstrb_o <= '0;
      rdata_q  <= '0;
      i_ack_o  <= 1'b0;
      d_ack_o  <= 1'b0;
      inval_o  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (inval_pend_q) begin
            state_q <= INVAL;
            inval_o <= 1'b1;
          end else if (grant) begin
            state_q   <= ISSUE;
            s_req_o   <= 1'b1;
            gnt_d_q   <= pick_d;
            last_d_q  <= pick_d;
            s_addr_o  <= pick_d ? d_addr_i  : i_addr_i;
            s_wdata_o <= pick_d ? d_wdata_i : i_wdata_i;
            s_wstrb_o <= pick_d ? d_wstrb_i : i_wstrb_i;
          end
        end
        ISSUE: begin
          if (s_ack_i) begin
            state_q <= RESP;
            s_req_o <= 1'b0;
            rdata_q <= s_rdata_i;
            i_ack_o <= ~gnt_d_q;
            d_ack_o <= gnt_d_q;
          end
        end
        RESP: begin
          i_ack_o <= 1'b0;
          d_ack_o <= 1'b0;
          state_q <= IDLE;
        end
        INVAL: begin
          inval_o <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Invalidate request is remembered until the INVAL state retires it; a new pulse wins.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      inval_pend_q <= 1'b0;
    end else if (inval_req_i) begin
      inval_pend_q <= 1'b1;
    end else if (state_q == INVAL) begin
      inval_pend_q <= 1'b0;
    end
  end

  assign i_rdata_o = rdata_q;
  assign d_rdata_o = rdata_q;

`ifdef EXT_MEM_BE_ARB_STATS_EN
  logic [31:0] i_cnt_q;
  logic [31:0] d_cnt_q;

  // Count grants per master; wraps naturally at 2^32.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      i_cnt_q <= '0;
      d_cnt_q <= '0;
    end else if (grant) begin
      if (pick_d) d_cnt_q <= d_cnt_q + 32'd1;
      else        i_cnt_q <= i_cnt_q + 32'd1;
    end
  end

  assign i_grant_cnt_o = i_cnt_q;
  assign d_grant_cnt_o = d_cnt_q;
`else
  assign i_grant_cnt_o = 32'd0;
  assign d_grant_cnt_o = 32'd0;
`endif

endmodule

// File: doc/ext_mem_be_arb.md
# ext_mem_be_arb

Arbiter between the instruction-cache and data-cache back-end buses and the single L2 cache front-end inside the external-memory subsystem. Grants one outstanding L2 access at a time with round-robin fairness, and registers the request and response paths. Sequences the data-cache invalidate command so the L2 is never invalidated while an access is outstanding.

## Interface
Parameters:
- ADDR_W, 24, byte-address width of the back-end buses and L2 front-end
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
- clk_i  in  1  clock
- arst_i  in  1  reset, asynchronous, active-high
- i_req_i  in  1  icache back-end request, held until i_ack_o
- i_addr_i, i_wdata_i, i_wstrb_i  in  ADDR_W, DATA_W, DATA_W/8  icache request fields
- i_rdata_o  out  DATA_W  read data to icache
- i_ack_o  out  1  one-cycle completion pulse to icache
- d_req_i, d_addr_i, d_wdata_i, d_wstrb_i  in  1, ADDR_W, DATA_W, DATA_W/8  dcache request
- d_rdata_o  out  DATA_W  read data to dcache
- d_ack_o  out  1  one-cycle completion pulse to dcache
- inval_req_i  in  1  invalidate request pulse from dcache control
- s_req_o, s_addr_o, s_wdata_o, s_wstrb_o  out  1, ADDR_W, DATA_W, DATA_W/8  request to L2
- s_rdata_i  in  DATA_W  L2 read data, valid with s_ack_i
- s_ack_i  in  1  L2 completion pulse
- inval_o  out  1  one-cycle invalidate pulse to L2
- i_grant_cnt_o, d_grant_cnt_o  out  32  grant counters (see Configuration)

## Operation
- FSM states IDLE, ISSUE, RESP, INVAL; reset state IDLE.
- inval_pend flag: set by inval_req_i (any state); cleared on leaving INVAL unless inval_req_i is high the same cycle (set wins).
- IDLE: inval_pend=1 -> INVAL (takes priority over requests). Else any req -> ISSUE, latch selected master's addr/wdata/wstrb into s_* registers, record grant.
- Round robin: only one req -> that master; both -> master not granted last. last_grant resets to D, so icache wins the first tie.
- ISSUE: s_req_o=1; on s_ack_i -> RESP, capture s_rdata_i into shared rdata register.
- RESP: ack pulse to granted master only; -> IDLE.
- INVAL: inval_o=1 for exactly one cycle; -> IDLE.
- Master req is sampled only in IDLE; req high during the master's ack cycle is never treated as a new request (master updates req after ack).
- Writes (wstrb≠0) and reads follow the identical sequence; rdata register updated on every completion.
- i_rdata_o and d_rdata_o both driven by the shared rdata register.

## Timing
- All outputs registered/state-decoded; reset value 0 for every output, s_* registers, rdata, counters, inval_pend.
- Request seen in IDLE at cycle 0 -> s_req_o high from cycle 1.
- s_ack_i at cycle k -> s_req_o low and x_ack_o high at cycle k+1 with rdata valid -> IDLE at k+2; next grant issues s_req_o at k+3 earliest.
- Zero-wait L2 (s_ack_i at cycle 1): master ack at cycle 2.
- inval_req_i during ISSUE/RESP: inval_o issued one cycle after return to IDLE, before any pending grant.
- s_* fields stable for the whole ISSUE state.
- arst_i mid-access: immediate return to IDLE, all outputs 0, outstanding access and pending invalidate dropped.

## Configuration
- EXT_MEM_BE_ARB_STATS_EN defined: i_grant_cnt_o/d_grant_cnt_o increment by 1 on each IDLE->ISSUE grant to that master, wrap at 2^32, reset 0.
- Undefined: counters not built, both ports tied to 0.

## Test plan
- Single icache read, addr 0x000100, L2 returns 0xDEADBEEF after 3 cycles -> s_req_o cycles 1-3, i_ack_o and i_rdata_o=0xDEADBEEF at cycle 4, d_ack_o stays 0.
- Both req at same cycle after reset -> icache granted first, dcache second; continuous both-req for 6 accesses -> grants I,D,I,D,I,D.
- dcache write addr 0x000040 wdata 0x12345678 wstrb 0xF -> s_addr_o/s_wdata_o/s_wstrb_o match and stay stable throughout ISSUE; d_ack_o one pulse.
- inval_req_i pulsed during ISSUE with icache request also pending -> inval_o one pulse after RESP/IDLE, strictly before next s_req_o.
- arst_i asserted in ISSUE -> all outputs 0 same cycle; after release, no ack for dropped access; new request completes normally.
- With EXT_MEM_BE_ARB_STATS_EN: 5 icache + 3 dcache accesses -> i_grant_cnt_o=5, d_grant_cnt_o=3; without macro both read 0.
